pc_unit: RTL and testbench

- Parametrised successor to the combinational next-PC logic in the multi-cycle MIPS datapath.
- Owns the PC register and computes the next PC: sequential, branch, jump, register jump and ERET.
- Adds exception redirection with EPC capture and a small return-address stack (RAS). The RAS flags JR $ra targets that do not match the predicted return.
- Sits between the multi-cycle controller (PCWrite/NPCOp) and instruction fetch/memory address mux.

---
 rtl/pc_unit_pkg.sv | 18 +
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared next-PC operation encodings and default vectors for the PC unit.
package pc_unit_pkg;

  localparam logic [2:0] NPC_PLUS4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH   = 3'd1;
  localparam logic [2:0] NPC_JUMP_IMM = 3'd2;
  localparam logic [2:0] NPC_JUMP_REG = 3'd3;
  localparam logic [2:0] NPC_ERET     = 3'd4;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

  // Only the two jump forms may write a return address onto the stack.
  function automatic logic is_link_op(input logic [2:0] op);
    return (op == NPC_JUMP_IMM) || (op == NPC_JUMP_REG);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace-top, oldest entry overwritten when full.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] top_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;

  // ptr_q names the next free slot; the top entry sits just below it.
  assign top_idx = ptr_q - PW'(1);
  assign wr_idx  = pop_i ? top_idx : ptr_q;
  assign valid_o = (cnt_q != '0);
  assign top_o   = valid_o ? mem_q[top_idx] : '0;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i && pop_i) begin
      if (cnt_q == '0) cnt_d = CW'(1);
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// PC register with next-PC selection, exception entry/ERET, EPC capture and
// a return-address stack that flags mispredicted function returns.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_we,
  input  logic [2:0]       npc_op,
  input  logic             br_take,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             link,
  input  logic             ret_hint,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] epc,
  output logic             exl,
  output logic             ras_valid,
  output logic [WIDTH-1:0] ras_top,
  output logic             ret_mispredict
);

  localparam logic [WIDTH-1:0] REGION_LOW = WIDTH'({28{1'b1}});

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
  logic             exl_q, exl_d, mis_q, mis_d;
  logic [WIDTH-1:0] pc_plus4, br_off, jmp_tgt;
  logic             exc_take, upd, ras_push, ras_pop;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
  // Jump keeps the 256 MB region of the delay-slot-free successor PC.
  assign jmp_tgt  = (pc_plus4 & ~REGION_LOW) | WIDTH'({imm26, 2'b00});

  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_BRANCH:   npc = br_take ? (pc_plus4 + br_off) : pc_plus4;
      NPC_JUMP_IMM: npc = jmp_tgt;
      NPC_JUMP_REG: npc = rs_val;
      NPC_ERET:     npc = epc_q;
      default:      npc = pc_plus4;
    endcase
  end

  // A misaligned register target faults even inside the handler.
  assign exc_take = pc_we && ((exc_req && !exl_q) ||
                              ((npc_op == NPC_JUMP_REG) && (rs_val[1:0] != 2'b00)));
  assign upd      = pc_we && !exc_take;
  assign ras_pop  = upd && (npc_op == NPC_JUMP_REG) && ret_hint;
  assign ras_push = upd && link && is_link_op(npc_op);

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    exl_d = exl_q;
    mis_d = 1'b0;
    if (exc_take) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
      exl_d = 1'b1;
    end else if (upd) begin
      pc_d = npc;
      if (npc_op == NPC_ERET) exl_d = 1'b0;
      if (ras_pop) mis_d = !ras_valid || (rs_val != ras_top);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      exl_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      exl_q <= exl_d;
      mis_q <= mis_d;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus4),
    .valid_o     (ras_valid),
    .top_o       (ras_top)
  );

  assign pc             = pc_q;
  assign epc            = epc_q;
  assign exl            = exl_q;
  assign ret_mispredict = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every cycle,
// plus directed vectors with literal expected values.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int W = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pc_we = 1'b0;
  logic [2:0]    npc_op = NPC_PLUS4;
  logic          br_take = 1'b0;
  logic [25:0]   imm26 = '0;
  logic [W-1:0]  rs_val = '0;
  logic          link = 1'b0;
  logic          ret_hint = 1'b0;
  logic          exc_req = 1'b0;
  logic [W-1:0]  pc, npc, epc, ras_top;
  logic          exl, ras_valid, ret_mispredict;

  int n_vec = 0;
  int n_err = 0;

  pc_unit #(
    .WIDTH     (W),
    .RESET_VEC (32'h0000_3000),
    .EXC_VEC   (32'h0000_4180),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_we          (pc_we),
    .npc_op         (npc_op),
    .br_take        (br_take),
    .imm26          (imm26),
    .rs_val         (rs_val),
    .link           (link),
    .ret_hint       (ret_hint),
    .exc_req        (exc_req),
    .pc             (pc),
    .npc            (npc),
    .epc            (epc),
    .exl            (exl),
    .ras_valid      (ras_valid),
    .ras_top        (ras_top),
    .ret_mispredict (ret_mispredict)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_pc, m_epc;
  logic         m_exl, m_mis;
  logic         model_ok = 1'b0;
  logic [W-1:0] exp_q[$];   // return-address stack, newest at the back

  function automatic logic [W-1:0] model_npc();
    logic [W-1:0] p4;
    int           off;
    p4 = m_pc + 32'd4;
    off = int'($signed(imm26[15:0])) * 4;
    case (npc_op)
      NPC_BRANCH:   return br_take ? p4 + W'(off) : p4;
      NPC_JUMP_IMM: return (p4 & 32'hF000_0000) | (W'(imm26) * 4);
      NPC_JUMP_REG: return rs_val;
      NPC_ERET:     return m_epc;
      default:      return p4;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] nxt, p4;
    logic         exc, pop, push;
    if (rst) begin
      m_pc = 32'h3000; m_epc = '0; m_exl = 1'b0; m_mis = 1'b0;
      exp_q.delete();
      model_ok = 1'b1;
    end else if (pc_we) begin
      exc = (exc_req && !m_exl) || (npc_op == NPC_JUMP_REG && rs_val[1:0] != 2'b00);
      m_mis = 1'b0;
      if (exc) begin
        m_epc = m_pc; m_pc = 32'h4180; m_exl = 1'b1;
      end else begin
        nxt  = model_npc();
        p4   = m_pc + 32'd4;
        pop  = (npc_op == NPC_JUMP_REG) && ret_hint;
        push = link && (npc_op == NPC_JUMP_IMM || npc_op == NPC_JUMP_REG);
        if (pop) m_mis = (exp_q.size() == 0) || (rs_val != exp_q[$]);
        if (pop && push) begin
          if (exp_q.size() == 0) exp_q.push_back(p4);
          else exp_q[$] = p4;
        end else if (pop) begin
          if (exp_q.size() != 0) void'(exp_q.pop_back());
        end else if (push) begin
          exp_q.push_back(p4);
          if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        end
        if (npc_op == NPC_ERET) m_exl = 1'b0;
        m_pc = nxt;
      end
    end else begin
      m_mis = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok && !rst) begin
      chk("pc", pc, m_pc);
      chk("npc", npc, model_npc());
      chk("epc", epc, m_epc);
      chk("exl", W'(exl), W'(m_exl));
      chk("ras_valid", W'(ras_valid), W'(exp_q.size() != 0));
      chk("ras_top", ras_top, (exp_q.size() != 0) ? exp_q[$] : '0);
      chk("ret_mispredict", W'(ret_mispredict), W'(m_mis));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic we, input logic [2:0] op, input logic [25:0] imm,
                      input logic [W-1:0] rs, input logic lnk, input logic hint,
                      input logic exc, input logic bt);
    pc_we = we; npc_op = op; imm26 = imm; rs_val = rs;
    link = lnk; ret_hint = hint; exc_req = exc; br_take = bt;
    @(posedge clk); #1;
  endtask

  task automatic plus4();
    step(1'b1, NPC_PLUS4, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jal(input logic [W-1:0] target);
    step(1'b1, NPC_JUMP_IMM, 26'(target >> 2), '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ret(input logic [W-1:0] rs);
    step(1'b1, NPC_JUMP_REG, '0, rs, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_exl", W'(exl), '0);
    chk("rst_epc", epc, '0);
    chk("rst_ras", W'(ras_valid), '0);

    plus4(); chk("seq1", pc, 32'h3004);
    plus4(); chk("seq2", pc, 32'h3008);
    plus4(); chk("seq3", pc, 32'h300C);
    step(1'b0, NPC_PLUS4, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold", pc, 32'h300C);
    chk("hold_exl", W'(exl), '0);

    plus4(); chk("to3010", pc, 32'h3010);
    step(1'b1, NPC_BRANCH, 26'h000FFFE, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("br_taken", pc, 32'h300C);
    plus4();
    step(1'b1, NPC_BRANCH, 26'h000FFFE, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_not_taken", pc, 32'h3014);

    repeat (3) plus4();
    chk("to3020", pc, 32'h3020);
    step(1'b1, NPC_JUMP_IMM, 26'h0000100, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jal_pc", pc, 32'h0000_0400);
    chk("jal_top", ras_top, 32'h3024);
    ret(32'h3024);
    chk("ret_pc", pc, 32'h3024);
    chk("ret_valid", W'(ras_valid), '0);
    chk("ret_ok", W'(ret_mispredict), '0);
    step(1'b1, NPC_JUMP_REG, '0, 32'h3020, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, NPC_JUMP_IMM, 26'h0000100, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ret(32'h3028);
    chk("ret_bad_pc", pc, 32'h3028);
    chk("ret_bad_mis", W'(ret_mispredict), 32'd1);
    plus4();
    chk("mis_pulse_end", W'(ret_mispredict), '0);
    chk("to302c", pc, 32'h302C);

    jal(32'h3100); chk("push1", ras_top, 32'h3030);
    jal(32'h3200); chk("push2", ras_top, 32'h3104);
    jal(32'h3300); chk("push3", ras_top, 32'h3204);
    jal(32'h3400); chk("push4", ras_top, 32'h3304);
    jal(32'h3500); chk("push5", ras_top, 32'h3404);
    ret(32'h3404); chk("pop1_mis", W'(ret_mispredict), '0); chk("pop1_top", ras_top, 32'h3304);
    ret(32'h3304); chk("pop2_top", ras_top, 32'h3204);
    ret(32'h3204); chk("pop3_top", ras_top, 32'h3104);
    ret(32'h3104); chk("pop4_mis", W'(ret_mispredict), '0); chk("pop4_valid", W'(ras_valid), '0);
    ret(32'h3030);
    chk("pop5_valid", W'(ras_valid), '0);
    chk("pop5_mis", W'(ret_mispredict), 32'd1);
    chk("pop5_pc", pc, 32'h3030);

    repeat (4) plus4();
    chk("to3040", pc, 32'h3040);
    step(1'b1, NPC_PLUS4, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("exc_pc", pc, 32'h4180);
    chk("exc_epc", epc, 32'h3040);
    chk("exc_exl", W'(exl), 32'd1);
    step(1'b1, NPC_PLUS4, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("exc_nested_pc", pc, 32'h4184);
    chk("exc_nested_epc", epc, 32'h3040);
    step(1'b1, NPC_ERET, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eret_pc", pc, 32'h3040);
    chk("eret_exl", W'(exl), '0);

    step(1'b1, NPC_JUMP_REG, '0, 32'h5002, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mis_align_pc", pc, 32'h4180);
    chk("mis_align_epc", epc, 32'h3040);
    chk("mis_align_ras", W'(ras_valid), '0);
    jal(32'h3100);
    chk("handler_push", W'(ras_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_pc", pc, 32'h3000);
    chk("mid_rst_ras", W'(ras_valid), '0);
    chk("mid_rst_exl", W'(exl), '0);

    // JALR that is also a return: top replaced, count becomes 1 from empty.
    step(1'b1, NPC_JUMP_REG, '0, 32'h3200, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("jalr_empty_top", ras_top, 32'h3004);
    chk("jalr_empty_mis", W'(ret_mispredict), 32'd1);
    step(1'b1, NPC_JUMP_REG, '0, 32'h3004, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("jalr_repl_top", ras_top, 32'h3204);
    chk("jalr_repl_mis", W'(ret_mispredict), '0);
    plus4();
    ret(32'h3204);
    chk("jalr_repl_empty", W'(ras_valid), '0);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] rs;
      rs = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
      if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1 && exp_q.size() != 0) rs = exp_q[$];
      step(1'($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)),
           26'($urandom), rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
